// File: rtl/div_issue_queue.sv
// Operand FIFO and issue controller in front of div_top: buffers (A,B) pairs,
// launches one division at a time, holds the result on a valid/ready port.
// Optional `DIV_ZERO_BYPASS_EN: zero divisors are answered locally and never reach div_top.
module div_issue_queue #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_a,
  input  logic [W-1:0]             in_b,
  output logic                     div_start,
  output logic [W-1:0]             div_a,
  output logic [W-1:0]             div_b,
  input  logic                     div_busy,
  input  logic                     div_valid,
  input  logic [W-1:0]             div_q,
  input  logic                     div_ov,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_q,
  output logic                     out_ov,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  a_mem [DEPTH];
  logic [W-1:0]  b_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [W-1:0]  head_a, head_b;
  logic          push, pop, load, capture, bypass;

  assign head_a    = a_mem[rd_ptr];
  assign head_b    = b_mem[rd_ptr];
  assign in_ready  = (level != FULL_LVL);
  assign push      = in_valid & in_ready;
  // Head stays resident while the divider works; it leaves only once a result exists.
  assign pop       = capture | bypass;
  assign div_start = (state == ISSUE);
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk) begin
    if (push) begin
      a_mem[wr_ptr] <= in_a;
      b_mem[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    capture   = 1'b0;
    bypass    = 1'b0;
    case (state)
      IDLE: begin
        if (level != '0) begin
`ifdef DIV_ZERO_BYPASS_EN
          if (head_b == '0) begin
            bypass    = 1'b1;
            state_nxt = HOLD;
          end else
`endif
          if (!div_busy) begin
            load      = 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (div_valid) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are held from load until the next load so div_top sees them stable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_a  <= '0;
      div_b  <= '0;
      out_q  <= '0;
      out_ov <= 1'b0;
    end else begin
      if (load) begin
        div_a <= head_a;
        div_b <= head_b;
      end
      if (capture) begin
        out_q  <= div_q;
        out_ov <= div_ov;
      end else if (bypass) begin
        out_q  <= '1;
        out_ov <= 1'b1;
      end
    end
  end

endmodule
